fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences the program counter and the instruction-memory fetch handshake for the MiniMicro core. It issues one outstanding 32-bit fetch at a time and buffers the returned word for decode. It applies branch/jump redirects with priority over sequential PC+4 and squashes stale in-flight responses. It sits between the PC register, the instruction memory port and the decode stage.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
TRAP_ADDR, 32'h0000_0010, vector taken on a misaligned redirect (only used with MISALIGN_TRAP_EN).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
fetch_stall  input  1  when 1, no new fetch request is issued
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  new PC for redirect
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch address (word aligned)
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  fetch data returned
imem_rsp_data  input  32  fetched instruction word
instr_valid  output  1  buffered instruction valid to decode
instr_data  output  32  buffered instruction
instr_pc  output  32  address of buffered instruction
instr_ready  input  1  decode consumes instruction
pc_out  output  32  current fetch PC register
misalign_fault  output  1  one-cycle pulse on misaligned redirect (0 when feature disabled)

Behaviour:
- States: REQ, WAIT, HOLD. Reset sets state=REQ, pc_out=RESET_ADDR, instr_valid=0, instr_data=0, instr_pc=0, kill=0, misalign_fault=0. imem_req_valid is 0 while rst=1.
- imem_req_valid = (state==REQ) & !fetch_stall & !redirect_valid & !rst. imem_req_addr = pc_out.
- REQ: on imem_req_valid & imem_req_ready: inflight_pc<=pc_out, pc_out<=pc_out+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go WAIT. Otherwise stay. Addr is stable while valid is held.
- WAIT: on imem_rsp_valid: if kill, discard, kill<=0, go REQ; else instr_data<=imem_rsp_data, instr_pc<=inflight_pc, instr_valid<=1, go HOLD.
- HOLD: instr_valid=1 and data/pc stable until instr_valid & instr_ready; then instr_valid<=0, go REQ.
- imem_rsp_valid outside WAIT is ignored.
- Redirect has highest priority, in any state: pc_out<=redirect_target and instr_valid<=0 next cycle.
  - REQ: the request is suppressed that cycle; stay REQ.
  - WAIT without rsp_valid: kill<=1, stay WAIT.
  - WAIT with rsp_valid the same cycle: the response is discarded and the state goes to REQ; kill is not set.
  - HOLD (with or without instr_ready): the buffer is dropped; go REQ.
- Redirect while kill=1 already: kill stays 1 and the latest target wins.
- fetch_stall affects only request issue. Responses and decode handoff continue.
- Minimum throughput: one instruction per 3 cycles (1-cycle memory). Only one request is ever outstanding.
- Reset asserted mid-operation: returns to the reset values next edge. Any later response to the old request arrives in REQ and is ignored.
- Without the optional feature: redirect_target[1:0] is forced to 2'b00 and misalign_fault stays 0.

Optional Feature:
MISALIGN_TRAP_EN. Defined: a redirect with redirect_target[1:0]!=0 loads pc_out<=TRAP_ADDR instead, pulses misalign_fault=1 for one cycle, and otherwise follows normal redirect rules. Undefined: low bits are masked to 00, misalign_fault is tied 0, and TRAP_ADDR is unused.

Test Plan:
- Reset, then imem_req_ready=1 with 1-cycle response of data 0x00000013 -> requests at 0x0, 0x4, 0x8; instr_pc 0x0 carries 0x00000013; pc_out reads 0x4 after the first accept.
- Decode backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr_data/instr_pc stable, imem_req_valid=0; release gives handoff and a new request next cycle.
- Redirect to 0x100 while in WAIT; the stale response arrives 2 cycles later -> response dropped, instr_valid stays 0, next request addr 0x100.
- Redirect to 0x200 in the same cycle as rsp_valid -> no instruction delivered; next request 0x200. fetch_stall=1 -> no imem_req_valid until cleared.
- pc_out=0xFFFFFFFC accepted -> pc_out becomes 0x00000000; instr_pc=0xFFFFFFFC.
- Redirect to 0x102: with MISALIGN_TRAP_EN -> misalign_fault pulses and the next request is 0x10; without it -> next request is 0x100 and the fault stays 0.

Source files
------------

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Program-counter sequencer and instruction-memory fetch handshake for the
// MiniMicro core. At most one 32-bit fetch is outstanding at any time. The
// returned word is held in a one-entry buffer until decode takes it. A
// branch/jump redirect takes priority over sequential PC+4. A redirect that
// lands while a fetch is in flight marks that fetch as stale, so its response
// is thrown away when it arrives.
//
// Optional feature (compile-time macro): MISALIGN_TRAP_EN
//   defined   : a redirect whose target[1:0] != 0 vectors to TRAP_ADDR and
//               raises misalign_fault for one cycle.
//   undefined : target[1:0] are forced to 2'b00, misalign_fault is tied 0 and
//               TRAP_ADDR is not used.
//
// Parameters:
//   RESET_ADDR       PC value loaded on reset
//   TRAP_ADDR        vector used for a misaligned redirect (feature only)
//
// Ports:
//   clk              core clock; all state changes on its rising edge
//   rst              synchronous active-high reset
//   fetch_stall      blocks issue of new fetch requests only
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new PC for the redirect
//   imem_req_valid   fetch request valid (address held while valid)
//   imem_req_addr    word-aligned fetch address (= pc_out)
//   imem_req_ready   memory accepts the request
//   imem_rsp_valid   fetched word returned
//   imem_rsp_data    fetched instruction word
//   instr_valid      buffered instruction valid towards decode
//   instr_data       buffered instruction word
//   instr_pc         address of the buffered instruction
//   instr_ready      decode consumes the buffered instruction
//   pc_out           current fetch PC register
//   misalign_fault   one-cycle pulse after a misaligned redirect
// -----------------------------------------------------------------------------
module fetch_controller #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] TRAP_ADDR  = 32'h0000_0010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic [31:0] pc_out,
   output logic        misalign_fault
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,   // ready to issue the next fetch
      ST_WAIT = 2'd1,   // one fetch outstanding, waiting for its response
      ST_HOLD = 2'd2    // buffer full, waiting for decode to take it
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_inflight_pc;
   logic [31:0] w_inflight_pc_next;
   logic [31:0] r_instr_data;
   logic [31:0] w_instr_data_next;
   logic [31:0] r_instr_pc;
   logic [31:0] w_instr_pc_next;
   logic        r_instr_valid;
   logic        w_instr_valid_next;
   logic        r_kill;
   logic        w_kill_next;
   logic        r_misalign;
   logic        w_misalign_next;

   logic        w_req_valid;
   logic        w_req_fire;
   logic        w_misaligned;
   logic [31:0] w_redirect_pc;

   // Redirect address resolution
`ifdef MISALIGN_TRAP_EN
   assign w_misaligned  = (redirect_target[1:0] != 2'b00);
   assign w_redirect_pc = w_misaligned ? TRAP_ADDR : redirect_target;
`else
   // Low bits are dropped so the PC can never become misaligned; the trap
   // vector and the dropped bits are deliberately left unused here.
   logic w_unused_bits;
   assign w_unused_bits = ^{TRAP_ADDR, redirect_target[1:0]};
   assign w_misaligned  = 1'b0;
   assign w_redirect_pc = {redirect_target[31:2], 2'b00};
`endif

   // A redirect in the same cycle suppresses the request so that the old
   // sequential address never reaches memory after a taken branch.
   assign w_req_valid = (r_state == ST_REQ) & ~fetch_stall & ~redirect_valid & ~rst;
   assign w_req_fire  = w_req_valid & imem_req_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_REQ;
         r_pc          <= RESET_ADDR;
         r_inflight_pc <= 32'h0000_0000;
         r_instr_data  <= 32'h0000_0000;
         r_instr_pc    <= 32'h0000_0000;
         r_instr_valid <= 1'b0;
         r_kill        <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_inflight_pc <= w_inflight_pc_next;
         r_instr_data  <= w_instr_data_next;
         r_instr_pc    <= w_instr_pc_next;
         r_instr_valid <= w_instr_valid_next;
         r_kill        <= w_kill_next;
         r_misalign    <= w_misalign_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next       = r_state;
      w_pc_next          = r_pc;
      w_inflight_pc_next = r_inflight_pc;
      w_instr_data_next  = r_instr_data;
      w_instr_pc_next    = r_instr_pc;
      w_instr_valid_next = r_instr_valid;
      w_kill_next        = r_kill;
      w_misalign_next    = 1'b0;

      if (redirect_valid) begin
         // Redirect wins over everything else in every state.
         w_pc_next          = w_redirect_pc;
         w_instr_valid_next = 1'b0;
         w_misalign_next    = w_misaligned;
         case (r_state)
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  // The response is consumed (and dropped) right now, so
                  // nothing is left in flight that would need squashing.
                  w_kill_next  = 1'b0;
                  w_state_next = ST_REQ;
               end else begin
                  w_kill_next  = 1'b1;
               end
            end
            ST_HOLD: w_state_next = ST_REQ;
            default: w_state_next = ST_REQ;
         endcase
      end else begin
         case (r_state)
            ST_REQ: begin
               if (w_req_fire) begin
                  w_inflight_pc_next = r_pc;
                  w_pc_next          = r_pc + 32'd4;
                  w_state_next       = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  w_state_next = r_kill ? ST_REQ : ST_HOLD;
                  w_kill_next  = 1'b0;
                  if (!r_kill) begin
                     w_instr_data_next  = imem_rsp_data;
                     w_instr_pc_next    = r_inflight_pc;
                     w_instr_valid_next = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  w_instr_valid_next = 1'b0;
                  w_state_next       = ST_REQ;
               end
            end
            default: w_state_next = ST_REQ;
         endcase
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign pc_out         = r_pc;
   assign instr_valid    = r_instr_valid;
   assign instr_data     = r_instr_data;
   assign instr_pc       = r_instr_pc;
   assign misalign_fault = r_misalign;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed scenarios followed by a randomized run. Expected values come from a
// behavioural model (PC, "fetch outstanding", "outstanding fetch is stale",
// one-entry decode buffer) and a simple memory model with random latency.
// Honours MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic [31:0] pc_out;
   logic        misalign_fault;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_controller dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_stall     (fetch_stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .instr_valid     (instr_valid),
      .instr_data      (instr_data),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .pc_out          (pc_out),
      .misalign_fault  (misalign_fault)
   );

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_inflight = 32'h0;
   logic [31:0] m_buf_data = 32'h0;
   logic [31:0] m_buf_pc = 32'h0;
   logic        m_out = 1'b0;     // a fetch is outstanding
   logic        m_stale = 1'b0;   // the outstanding fetch must be dropped
   logic        m_buf = 1'b0;     // decode buffer holds a word
   logic        m_fault = 1'b0;

`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] EXP_MIS_ADDR  = 32'h0000_0010;
   localparam logic        EXP_MIS_FAULT = 1'b1;
`else
   localparam logic [31:0] EXP_MIS_ADDR  = 32'h0000_0100;
   localparam logic        EXP_MIS_FAULT = 1'b0;
`endif

   function automatic logic [31:0] exp_target(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
      return ((t % 4) != 0) ? 32'h0000_0010 : t;
`else
      return t - (t % 4);
`endif
   endfunction

   function automatic logic exp_mis(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
      return (t % 4) != 0;
`else
      return (t == t) ? 1'b0 : 1'b0;
`endif
   endfunction

   // A fetch can be issued only when nothing is in flight and the buffer is empty.
   function automatic logic exp_req();
      return !rst && !fetch_stall && !redirect_valid && !m_out && !m_buf;
   endfunction

   // Advance the model with the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic fire;
      fire = exp_req() && imem_req_ready;
      if (rst) begin
         m_pc = 32'h0; m_inflight = 32'h0; m_buf_data = 32'h0; m_buf_pc = 32'h0;
         m_out = 1'b0; m_stale = 1'b0; m_buf = 1'b0; m_fault = 1'b0;
      end else if (redirect_valid) begin
         m_pc    = exp_target(redirect_target);
         m_fault = exp_mis(redirect_target);
         m_buf   = 1'b0;
         if (m_out) begin
            if (imem_rsp_valid) begin m_out = 1'b0; m_stale = 1'b0; end
            else m_stale = 1'b1;
         end
      end else begin
         m_fault = 1'b0;
         if (fire) begin
            m_inflight = m_pc; m_pc = m_pc + 32'd4; m_out = 1'b1;
         end else if (m_out && imem_rsp_valid) begin
            m_out = 1'b0;
            if (m_stale) m_stale = 1'b0;
            else begin m_buf = 1'b1; m_buf_data = imem_rsp_data; m_buf_pc = m_inflight; end
         end else if (m_buf && instr_ready) begin
            m_buf = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; fetch_stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; instr_ready = 1'b1;
      tick(); tick();
      #1;
      n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
      n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 00000000", pc_out); end
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
      n_vec++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_buffer got %h/%h exp 0/0", instr_data, instr_pc); end
      n_vec++; if (misalign_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b exp 0", misalign_fault); end
      rst = 1'b0;
      $display("reset: pc=%h instr_valid=%b", pc_out, instr_valid);
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         imem_rsp_valid = 1'b0;
         #1;
         n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
            n_err++; $display("FAIL seq_req got %b@%h exp 1@%h", imem_req_valid, imem_req_addr, 32'(4 * k)); end
         tick();
         n_vec++; if (pc_out !== 32'(4 * k + 4)) begin n_err++; $display("FAIL seq_pc got %h exp %h", pc_out, 32'(4 * k + 4)); end
         imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
         tick();
         imem_rsp_valid = 1'b0;
         n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr_data !== 32'h13) begin
            n_err++; $display("FAIL seq_instr got v=%b pc=%h d=%h exp v=1 pc=%h d=00000013", instr_valid, instr_pc, instr_data, 32'(4 * k)); end
         $display("seq: fetch pc=%h data=%h", instr_pc, instr_data);
         tick();
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b0;
      #1; tick();                       // accept 0xC
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0001;
      tick();
      imem_rsp_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_vec++; if (instr_valid !== 1'b1 || instr_data !== 32'hCAFE_0001 || instr_pc !== 32'hC || imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_stable got v=%b d=%h pc=%h req=%b exp 1/cafe0001/0000000c/0", instr_valid, instr_data, instr_pc, imem_req_valid); end
         tick();
      end
      instr_ready = 1'b1;
      tick();
      n_vec++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
         n_err++; $display("FAIL hold_release got v=%b req=%b@%h exp 0 1@00000010", instr_valid, imem_req_valid, imem_req_addr); end
      $display("backpressure: released, next req %h", imem_req_addr);
   endtask

   task automatic test_redirect_wait();
      tick();                           // accept 0x10
      redirect_valid = 1'b1; redirect_target = 32'h100;
      tick();
      redirect_valid = 1'b0;
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;   // stale response
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL kill_drop got instr_valid %b exp 0", instr_valid); end
      n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         n_err++; $display("FAIL kill_next_req got %b@%h exp 1@00000100", imem_req_valid, imem_req_addr); end
      $display("redirect_wait: next req %h", imem_req_addr);
   endtask

   task automatic test_redirect_rsp_same_cycle();
      tick();                           // accept 0x100
      redirect_valid = 1'b1; redirect_target = 32'h200;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
      tick();
      redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
      #1;
      n_vec++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         n_err++; $display("FAIL same_cycle got v=%b req=%b@%h exp 0 1@00000200", instr_valid, imem_req_valid, imem_req_addr); end
      fetch_stall = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++; if (imem_req_valid !== 1'b0 || pc_out !== 32'h200) begin
            n_err++; $display("FAIL stall got req=%b pc=%h exp 0 00000200", imem_req_valid, pc_out); end
         tick();
      end
      fetch_stall = 1'b0;
      #1;
      n_vec++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_release got req=%b exp 1", imem_req_valid); end
      $display("same_cycle/stall: req %h", imem_req_addr);
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      #1;
      n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redirect_suppress got req=%b exp 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_req got %b@%h exp 1@fffffffc", imem_req_valid, imem_req_addr); end
      tick();
      n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 00000000", pc_out); end
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
      tick();
      imem_rsp_valid = 1'b0;
      n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_instr_pc got v=%b pc=%h exp 1 fffffffc", instr_valid, instr_pc); end
      $display("wrap: instr_pc=%h pc=%h", instr_pc, pc_out);
      tick();
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_target = 32'h102;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (misalign_fault !== EXP_MIS_FAULT) begin n_err++; $display("FAIL mis_fault got %b exp %b", misalign_fault, EXP_MIS_FAULT); end
      n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== EXP_MIS_ADDR) begin
         n_err++; $display("FAIL mis_req got %b@%h exp 1@%h", imem_req_valid, imem_req_addr, EXP_MIS_ADDR); end
      tick();                           // accept
      n_vec++; if (misalign_fault !== 1'b0) begin n_err++; $display("FAIL mis_pulse got %b exp 0", misalign_fault); end
      $display("misalign: fault=%b req=%h", EXP_MIS_FAULT, EXP_MIS_ADDR);
   endtask

   task automatic test_mid_reset();
      rst = 1'b1;                       // fetch is outstanding here
      tick();
      rst = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;   // late response to old fetch
      #1;
      n_vec++; if (pc_out !== 32'h0 || instr_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst_state got pc=%h v=%b exp 00000000 0", pc_out, instr_valid); end
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      n_vec++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         n_err++; $display("FAIL midrst_ignore got v=%b req=%b@%h exp 0 1@00000000", instr_valid, imem_req_valid, imem_req_addr); end
      $display("mid_reset: old response ignored");
   endtask

   task automatic test_random();
      logic        mem_busy = 1'b0;
      int          mem_cnt = 0;
      logic [31:0] mem_data = 32'h0;
      int          n_instr = 0;
      for (int c = 0; c < 3000; c++) begin
         rst             = ($urandom_range(0, 299) == 0);
         fetch_stall     = ($urandom_range(0, 7) == 0);
         redirect_valid  = ($urandom_range(0, 15) == 0);
         redirect_target = $urandom();
         instr_ready     = ($urandom_range(0, 2) != 0);
         imem_req_ready  = !mem_busy && ($urandom_range(0, 3) != 0);
         if (mem_busy && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = mem_data;
         end else if (!mem_busy && $urandom_range(0, 15) == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = $urandom();   // spurious, must be ignored
         end else begin
            imem_rsp_valid = 1'b0;
         end
         #1;
         n_vec++; if (imem_req_valid !== exp_req()) begin n_err++; $display("FAIL rnd_req_valid cyc %0d got %b exp %b", c, imem_req_valid, exp_req()); end
         n_vec++; if (pc_out !== m_pc || imem_req_addr !== m_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h/%h exp %h", c, pc_out, imem_req_addr, m_pc); end
         n_vec++; if (instr_valid !== m_buf) begin n_err++; $display("FAIL rnd_instr_valid cyc %0d got %b exp %b", c, instr_valid, m_buf); end
         if (m_buf) begin
            n_vec++; if (instr_data !== m_buf_data || instr_pc !== m_buf_pc) begin
               n_err++; $display("FAIL rnd_instr cyc %0d got %h@%h exp %h@%h", c, instr_data, instr_pc, m_buf_data, m_buf_pc); end
            if (instr_ready && !redirect_valid && !rst) n_instr++;
         end
         n_vec++; if (misalign_fault !== m_fault) begin n_err++; $display("FAIL rnd_fault cyc %0d got %b exp %b", c, misalign_fault, m_fault); end
         // memory model bookkeeping
         if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
         else if (mem_busy) mem_cnt--;
         if (exp_req() && imem_req_ready) begin
            mem_busy = 1'b1; mem_cnt = $urandom_range(0, 2);
            mem_data = $urandom();
         end
         tick();
      end
      rst = 1'b0; redirect_valid = 1'b0; fetch_stall = 1'b0; imem_rsp_valid = 1'b0;
      $display("random: 3000 cycles, %0d instructions handed to decode", n_instr);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rsp_same_cycle();
      test_wrap();
      test_misalign();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
